// File: rtl/flag_branch_ctrl.sv
// EX-stage flag register, BRFL condition resolution and IF redirect / flush sequencing.
// Optional branch statistics counters are compiled in with `define BRFL_STATS_EN.
module flag_branch_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flag_we,
    input  logic [2:0]            flag_in,
    input  logic                  brfl_valid,
    input  logic [2:0]            brfl_cond,
    input  logic [ADDR_WIDTH-1:0] brfl_target,
    input  logic                  pc_ack,
    output logic [2:0]            flag_q,
    output logic                  branch_req,
    output logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  resolved_o,
    output logic                  taken_o,
    output logic                  stall_ex,
    output logic                  flush_o
`ifdef BRFL_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_taken,
    output logic [15:0]           stat_not_taken
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] COND_MAX   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [2:0]              flush_cnt_q;
    logic [2:0]              flush_cnt_d;
    logic [2:0]              flag_d;
    logic                    branch_req_d;
    logic [ADDR_WIDTH-1:0]   branch_target_d;
    logic                    resolved_d;
    logic                    taken_d;
    logic                    stall_d;
    logic                    flush_d;

    logic [2:0]              eff_flag_p0;
    logic                    cond_hit_p0;

    // Evaluation stage: same-cycle flag bypass so a BRFL right after a flag op sees it
    always_comb begin
        eff_flag_p0 = flag_we ? flag_in : flag_q;
        cond_hit_p0 = brfl_valid && (brfl_cond == eff_flag_p0) && (brfl_cond <= COND_MAX);
    end

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        flag_d          = flag_q;
        branch_req_d    = branch_req;
        branch_target_d = branch_target;
        resolved_d      = 1'b0;
        taken_d         = 1'b0;
        stall_d         = stall_ex;
        flush_d         = flush_o;

        case (state_q)
            ST_IDLE: begin
                stall_d = 1'b0;
                flush_d = 1'b0;
                if (flag_we) begin
                    flag_d = flag_in;
                end
                if (brfl_valid) begin
                    resolved_d = 1'b1;
                    taken_d    = cond_hit_p0;
                    if (cond_hit_p0) begin
                        branch_req_d    = 1'b1;
                        branch_target_d = brfl_target;
                        stall_d         = 1'b1;
                        state_d         = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (pc_ack) begin
                    branch_req_d = 1'b0;
                    flush_d      = 1'b1;
                    stall_d      = 1'b1;
                    flush_cnt_d  = FLUSH_LOAD;
                    state_d      = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q != 3'd0) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end else begin
                    flush_d = 1'b0;
                    stall_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                branch_req_d = 1'b0;
                flush_d      = 1'b0;
                stall_d      = 1'b0;
                flush_cnt_d  = 3'd0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // Output stage: everything leaves through a flop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= 3'd0;
            flag_q        <= 3'b000;
            branch_req    <= 1'b0;
            branch_target <= '0;
            resolved_o    <= 1'b0;
            taken_o       <= 1'b0;
            stall_ex      <= 1'b0;
            flush_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            flag_q        <= flag_d;
            branch_req    <= branch_req_d;
            branch_target <= branch_target_d;
            resolved_o    <= resolved_d;
            taken_o       <= taken_d;
            stall_ex      <= stall_d;
            flush_o       <= flush_d;
        end
    end

`ifdef BRFL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic inc_taken;
    logic inc_not_taken;

    assign inc_taken     = (state_q == ST_IDLE) && brfl_valid && cond_hit_p0;
    assign inc_not_taken = (state_q == ST_IDLE) && brfl_valid && !cond_hit_p0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_taken     <= 16'd0;
            stat_not_taken <= 16'd0;
        end else if (stat_clr) begin
            stat_taken     <= 16'd0;
            stat_not_taken <= 16'd0;
        end else begin
            if (inc_taken) begin
                stat_taken <= sat_inc(stat_taken);
            end
            if (inc_not_taken) begin
                stat_not_taken <= sat_inc(stat_not_taken);
            end
        end
    end
`endif

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Self-checking bench for flag_branch_ctrl: directed scenarios followed by randomized traffic
// compared against a transaction-level reference model.
module tb_flag_branch_ctrl;

    localparam int AW    = 32;
    localparam int FLUSH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flag_we = 1'b0;
    logic [2:0]    flag_in = 3'b000;
    logic          brfl_valid = 1'b0;
    logic [2:0]    brfl_cond = 3'b000;
    logic [AW-1:0] brfl_target = '0;
    logic          pc_ack = 1'b0;
    logic [2:0]    flag_q;
    logic          branch_req;
    logic [AW-1:0] branch_target;
    logic          resolved_o;
    logic          taken_o;
    logic          stall_ex;
    logic          flush_o;
`ifdef BRFL_STATS_EN
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_taken;
    logic [15:0]   stat_not_taken;
`endif

    flag_branch_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FLUSH)) dut (
        .clock         (clock),
        .reset         (reset),
        .flag_we       (flag_we),
        .flag_in       (flag_in),
        .brfl_valid    (brfl_valid),
        .brfl_cond     (brfl_cond),
        .brfl_target   (brfl_target),
        .pc_ack        (pc_ack),
        .flag_q        (flag_q),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .resolved_o    (resolved_o),
        .taken_o       (taken_o),
        .stall_ex      (stall_ex),
        .flush_o       (flush_o)
`ifdef BRFL_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_taken    (stat_taken),
        .stat_not_taken(stat_not_taken)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: redirect pending flag plus remaining flush cycles
    logic [2:0]    m_flag = 3'b000;
    bit            m_pending = 1'b0;
    int            m_flush_left = 0;
    logic [AW-1:0] m_target = '0;
    bit            m_resolved = 1'b0;
    bit            m_taken = 1'b0;
    int            m_st_t = 0;
    int            m_st_nt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flag = 3'b000; m_pending = 1'b0; m_flush_left = 0; m_target = '0;
        m_resolved = 1'b0; m_taken = 1'b0; m_st_t = 0; m_st_nt = 0;
    endtask

    task automatic compare_all();
        chk("flag_q", 32'(flag_q), 32'(m_flag));
        chk("branch_req", 32'(branch_req), 32'(m_pending));
        if (m_pending) chk("branch_target", branch_target, m_target);
        chk("resolved_o", 32'(resolved_o), 32'(m_resolved));
        chk("taken_o", 32'(taken_o), 32'(m_taken));
        chk("stall_ex", 32'(stall_ex), 32'(m_pending || m_flush_left > 0));
        chk("flush_o", 32'(flush_o), 32'(m_flush_left > 0));
`ifdef BRFL_STATS_EN
        chk("stat_taken", 32'(stat_taken), 32'(m_st_t));
        chk("stat_not_taken", 32'(stat_not_taken), 32'(m_st_nt));
`endif
    endtask

    // Advance the model by one clock using the currently driven inputs, then compare
    task automatic tick();
        logic [2:0] eff;
        bit         tk;
        m_resolved = 1'b0;
        m_taken    = 1'b0;
        if (!m_pending && m_flush_left == 0) begin
            eff = flag_we ? flag_in : m_flag;
            if (brfl_valid) begin
                tk = (brfl_cond == eff) && (brfl_cond <= 3'd5);
                m_resolved = 1'b1;
                m_taken    = tk;
                if (tk) begin
                    m_pending = 1'b1;
                    m_target  = brfl_target;
                    if (m_st_t < 65535) m_st_t++;
                end else begin
                    if (m_st_nt < 65535) m_st_nt++;
                end
            end
            if (flag_we) m_flag = flag_in;
        end else if (m_pending) begin
            if (pc_ack) begin
                m_pending    = 1'b0;
                m_flush_left = FLUSH;
            end
        end else begin
            m_flush_left--;
        end
`ifdef BRFL_STATS_EN
        if (stat_clr) begin
            m_st_t  = 0;
            m_st_nt = 0;
        end
`endif
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        flag_we = 1'b0; brfl_valid = 1'b0; pc_ack = 1'b0;
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_target", branch_target, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        compare_all();
    endtask

    task automatic set_flag(input logic [2:0] f);
        idle_inputs();
        flag_we = 1'b1; flag_in = f;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic drain_redirect();
        idle_inputs();
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        for (int i = 0; i < 20 && stall_ex; i++) tick();
        chk("drain_idle", 32'(stall_ex), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int req_cycles;
        int flush_cycles;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        chk("rst_target0", branch_target, 32'h0);
        reset = 1'b1;

        // Flag load
        set_flag(3'b011);
        chk("flag_load", 32'(flag_q), 32'h3);

        // Taken with delayed acknowledge; flag writes and BRFLs during redirect are ignored
        set_flag(3'b001);
        brfl_valid = 1'b1; brfl_cond = 3'b001; brfl_target = 32'h0000_0040;
        tick();
        chk("tk_resolved", 32'(resolved_o), 32'h1);
        chk("tk_taken", 32'(taken_o), 32'h1);
        chk("tk_target", branch_target, 32'h40);
        req_cycles = branch_req ? 1 : 0;
        flag_we = 1'b1; flag_in = 3'b010; brfl_valid = 1'b1; brfl_cond = 3'b010;
        brfl_target = 32'hDEAD_BEEF;
        repeat (3) begin
            tick();
            if (branch_req) req_cycles++;
        end
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        chk("req_len", 32'(req_cycles), 32'd4);
        flush_cycles = 0;
        for (int i = 0; i < 20 && flush_o; i++) begin
            flush_cycles++;
            tick();
        end
        chk("flush_len", 32'(flush_cycles), 32'(FLUSH));
        chk("flag_held", 32'(flag_q), 32'h1);
        idle_inputs();
        tick();

        // Same-cycle bypass
        set_flag(3'b000);
        flag_we = 1'b1; flag_in = 3'b101; brfl_valid = 1'b1; brfl_cond = 3'b101;
        brfl_target = 32'h0000_1234;
        tick();
        chk("bypass_taken", 32'(taken_o), 32'h1);
        chk("bypass_flag", 32'(flag_q), 32'h5);
        drain_redirect();

        // Not taken, illegal condition, back-to-back resolutions
        set_flag(3'b100);
        brfl_valid = 1'b1; brfl_cond = 3'b001;
        tick();
        chk("nt_taken", 32'(taken_o), 32'h0);
        chk("nt_stall", 32'(stall_ex), 32'h0);
        tick();
        chk("b2b_resolved", 32'(resolved_o), 32'h1);
        set_flag(3'b111);
        brfl_valid = 1'b1; brfl_cond = 3'b111;
        tick();
        chk("illegal_taken", 32'(taken_o), 32'h0);
        idle_inputs();
        tick();

        // Reset in the middle of a redirect request
        set_flag(3'b010);
        brfl_valid = 1'b1; brfl_cond = 3'b010; brfl_target = 32'h0000_0800;
        tick();
        idle_inputs();
        tick();
        async_reset();
        chk("mid_rst_flag", 32'(flag_q), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                flag_we     = ($urandom_range(0, 3) == 0);
                flag_in     = 3'($urandom_range(0, 7));
                brfl_valid  = ($urandom_range(0, 1) == 1);
                brfl_cond   = ($urandom_range(0, 1) == 1) ? (flag_we ? flag_in : m_flag)
                                                          : 3'($urandom_range(0, 7));
                brfl_target = $urandom;
                pc_ack      = ($urandom_range(0, 2) == 0);
`ifdef BRFL_STATS_EN
                stat_clr    = ($urandom_range(0, 49) == 0);
`endif
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
